// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU data-memory access path.
// Contents:
//   - default widths and depth for the data memory
//   - the controller state encoding
//   - the memory read latency (rd_en sampled -> data_out valid)
//   - a helper that flags request addresses outside the memory
package cpu_mem_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 6;
  localparam int DEPTH_DEF  = 64;
  localparam int REQ_ADDR_W = 16;
  // The RD -> CAP -> RESP sequence is built around this one-cycle latency.
  localparam int MEM_RD_LAT = 1;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_WR   = 3'd2,
    ST_RD   = 3'd3,
    ST_CAP  = 3'd4,
    ST_RESP = 3'd5
  } state_t;

  // Any set bit above the memory word-address range is an error.
  function automatic logic addr_oob(input logic [REQ_ADDR_W-1:0] addr,
                                    input int unsigned           aw);
    return (addr >> aw) != '0;
  endfunction

endpackage

// File: rtl/data_mem_access_ctrl_if.sv
// Request/response handshake bundle between the execute stage (master)
// and the data-memory access controller (slave).
// Signals:
//   req_valid/req_ready  request handshake
//   req_we               1 = store, 0 = load
//   req_addr             16-bit word address from the ALU
//   req_wdata            store data
//   resp_valid/resp_ready response handshake
//   resp_rdata           load data (0 for stores and errors)
//   resp_err             address out of range, no access performed
interface data_mem_access_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [15:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_access_ctrl.sv
// Data-memory access controller: initiator side of the data-memory port.
// Accepts one load/store at a time from the datapath, drives the memory
// strobes, captures read data and returns a response. After reset it can
// sweep the whole memory to zero before taking requests.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   bus          request/response handshake (slave side)
//   init_done    clear sweep finished (or skipped)
//   mem_wr_en    memory write strobe
//   mem_rd_en    memory read strobe
//   mem_address  memory word address
//   mem_data_in  memory write data
//   mem_data_out memory read data, valid the cycle after rd_en is sampled
module data_mem_access_ctrl
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  data_mem_access_ctrl_if.slave bus,
  output logic                  init_done,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W-1:0]     mem_data_in,
  input  logic [DATA_W-1:0]     mem_data_out
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t state, state_d;

  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              init_done_d;
  logic              wr_en_d, rd_en_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] din_d;

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

  // Every output is a flop loaded with the value belonging to the state
  // being entered, so the strobes line up with the state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= INIT_CLEAR ? ST_INIT : ST_IDLE;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      init_done    <= !INIT_CLEAR;
      mem_wr_en    <= 1'b0;
      mem_rd_en    <= 1'b0;
      mem_address  <= '0;
      mem_data_in  <= '0;
    end else begin
      state        <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      init_done    <= init_done_d;
      mem_wr_en    <= wr_en_d;
      mem_rd_en    <= rd_en_d;
      mem_address  <= addr_d;
      mem_data_in  <= din_d;
    end
  end

  always_comb begin
    state_d      = state;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    init_done_d  = init_done;
    wr_en_d      = 1'b0;
    rd_en_d      = 1'b0;
    addr_d       = mem_address;
    din_d        = mem_data_in;

    unique case (state)
      // mem_address doubles as the sweep counter. The first INIT cycle
      // after reset has no write in progress yet (wr_en low), so it
      // launches address 0; each later cycle advances by one until the
      // write of the last word has been presented.
      ST_INIT: begin
        if (!mem_wr_en) begin
          wr_en_d = 1'b1;
          addr_d  = '0;
          din_d   = '0;
        end else if (mem_address == LAST_ADDR) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
          req_ready_d = 1'b1;
        end else begin
          wr_en_d = 1'b1;
          addr_d  = mem_address + ADDR_W'(1);
          din_d   = '0;
        end
      end

      // req_ready_q can be low in IDLE only for the first cycle after a
      // reset without a clear sweep; no request is taken in that cycle.
      ST_IDLE: begin
        if (req_ready_q && bus.req_valid) begin
          if (addr_oob(bus.req_addr, ADDR_W)) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (bus.req_we) begin
            state_d = ST_WR;
            wr_en_d = 1'b1;
            addr_d  = bus.req_addr[ADDR_W-1:0];
            din_d   = bus.req_wdata;
          end else begin
            state_d = ST_RD;
            rd_en_d = 1'b1;
            addr_d  = bus.req_addr[ADDR_W-1:0];
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end

      ST_WR: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
      end

      // Memory samples rd_en at the end of RD; data is on data_out
      // throughout CAP and is captured as CAP hands over to RESP.
      ST_RD: begin
        state_d = ST_CAP;
      end

      ST_CAP: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = mem_data_out;
      end

      ST_RESP: begin
        if (bus.resp_ready) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
        end else begin
          resp_valid_d = 1'b1;
          resp_rdata_d = resp_rdata_q;
          resp_err_d   = resp_err_q;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_data_mem_access_ctrl.sv
module tb_data_mem_access_ctrl;

  localparam int DW = 16;
  localparam int AW = 6;
  localparam int DP = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          init_done;
  logic          mem_wr_en, mem_rd_en;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out = '0;

  data_mem_access_ctrl_if #(.DATA_W(DW)) bus ();

  data_mem_access_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .INIT_CLEAR(1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .init_done   (init_done),
    .mem_wr_en   (mem_wr_en),
    .mem_rd_en   (mem_rd_en),
    .mem_address (mem_address),
    .mem_data_in (mem_data_in),
    .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memory, seeded with non-zero contents so the sweep shows.
  logic [DW-1:0] mem [DP];
  bit seeded = 1'b0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < DP; i++) mem[i] <= DW'(16'hA500 | i);
      seeded <= 1'b1;
    end else begin
      if (mem_wr_en) mem[mem_address] <= mem_data_in;
      if (mem_rd_en) mem_data_out <= mem[mem_address];
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            acc;
    int            lat;
    int            hold;
  } exp_t;
  exp_t sb[$];

  // Strobe activity after the sweep, plus any cycle with both strobes high.
  int wr_pulses = 0, rd_pulses = 0, overlap = 0;
  initial forever begin
    @(negedge clk);
    if (mem_wr_en && mem_rd_en) overlap++;
    if (init_done && mem_wr_en) wr_pulses++;
    if (init_done && mem_rd_en) rd_pulses++;
  end

  // Response monitor: pops the scoreboard, checks latency, data and
  // stability, and applies the entry's resp_ready back-pressure.
  initial begin
    int   vcnt;
    exp_t e;
    vcnt = 0;
    bus.resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && bus.resp_valid) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL resp_unexpected: resp_valid=1 with no outstanding request (cycle %0d)", cyc);
          bus.resp_ready = 1'b0;
        end else begin
          e = sb[0];
          if (vcnt == 0) chk("latency", cyc - e.acc + 1, e.lat);
          chk("resp_rdata", bus.resp_rdata, e.rdata);
          chk("resp_err", bus.resp_err, e.err);
          chk("req_ready_busy", bus.req_ready, 1'b0);
          if (vcnt >= e.hold) begin
            bus.resp_ready = 1'b1;
            void'(sb.pop_front());
            vcnt = 0;
          end else begin
            bus.resp_ready = 1'b0;
            vcnt++;
          end
        end
      end else begin
        bus.resp_ready = 1'b0;
        vcnt = 0;
      end
    end
  end

  task automatic do_req(input logic we, input logic [15:0] addr, input logic [DW-1:0] wdata,
                        input logic [DW-1:0] exp_rdata, input logic exp_err,
                        input int lat, input int hold);
    int   t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (!bus.req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      chk("req_ready_timeout", 32'd0, 32'd1);
    end else begin
      e.rdata = exp_rdata; e.err = exp_err; e.acc = cyc + 1; e.lat = lat; e.hold = hold;
      sb.push_back(e);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      @(negedge clk);
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(sb.size() == 0 && bus.req_ready) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"},  bus.req_ready, 1'b0);
    chk({tag, "_resp_valid"}, bus.resp_valid, 1'b0);
    chk({tag, "_resp_rdata"}, bus.resp_rdata, '0);
    chk({tag, "_resp_err"},   bus.resp_err, 1'b0);
    chk({tag, "_init_done"},  init_done, 1'b0);
    chk({tag, "_wr_en"},      mem_wr_en, 1'b0);
    chk({tag, "_rd_en"},      mem_rd_en, 1'b0);
    chk({tag, "_address"},    mem_address, '0);
    chk({tag, "_data_in"},    mem_data_in, '0);
  endtask

  task automatic sweep_check(input string tag);
    int ok;
    ok = 0;
    for (int i = 0; i < DP; i++) begin
      @(negedge clk);
      if (mem_wr_en && !mem_rd_en && mem_address == AW'(i) && mem_data_in == '0) ok++;
    end
    chk({tag, "_writes"}, ok, DP);
    @(negedge clk);
    chk({tag, "_init_done"}, init_done, 1'b1);
    chk({tag, "_req_ready"}, bus.req_ready, 1'b1);
    chk({tag, "_wr_after"},  mem_wr_en, 1'b0);
  endtask

  initial begin
    int nz, wr0, rd0, t;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_all_zero("reset");

    // Clear sweep
    rst = 1'b1;
    sweep_check("sweep");
    nz = 0;
    for (int i = 0; i < DP; i++) if (mem[i] != '0) nz++;
    chk("mem_cleared", nz, 0);

    // Store then load, latencies 2 and 3
    do_req(1'b1, 16'h0005, 16'hBEEF, 16'h0000, 1'b0, 2, 0);
    wait_idle();
    chk("mem5_written", mem[5], 16'hBEEF);
    chk("store_wr_pulses", wr_pulses, 1);
    do_req(1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0, 3, 0);
    wait_idle();
    chk("load_rd_pulses", rd_pulses, 1);

    // Out-of-range load: error, no strobe
    wr0 = wr_pulses; rd0 = rd_pulses;
    do_req(1'b0, 16'h0040, 16'h0000, 16'h0000, 1'b1, 1, 0);
    wait_idle();
    chk("err_no_wr", wr_pulses, wr0);
    chk("err_no_rd", rd_pulses, rd0);

    // Load with resp_ready withheld for 5 response cycles
    do_req(1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0, 3, 5);
    wait_idle();

    // Edge addresses back-to-back
    do_req(1'b1, 16'h003F, 16'h1234, 16'h0000, 1'b0, 2, 0);
    do_req(1'b1, 16'h0000, 16'hCAFE, 16'h0000, 1'b0, 2, 0);
    do_req(1'b0, 16'h003F, 16'h0000, 16'h1234, 1'b0, 3, 0);
    do_req(1'b0, 16'h0000, 16'h0000, 16'hCAFE, 1'b0, 3, 0);
    wait_idle();

    // Out-of-range store: top bit only, memory untouched
    wr0 = wr_pulses;
    do_req(1'b1, 16'h8000, 16'h5555, 16'h0000, 1'b1, 1, 0);
    wait_idle();
    chk("err_store_no_wr", wr_pulses, wr0);
    chk("err_store_mem0", mem[0], 16'hCAFE);

    // Reset during CAP of a load: response must never appear
    t = 0;
    @(negedge clk);
    while (!bus.req_ready && t < 50) begin @(negedge clk); t++; end
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 16'h0005;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("abort_rd_en", mem_rd_en, 1'b1);
    @(negedge clk);
    chk("abort_cap_rd_en", mem_rd_en, 1'b0);
    chk("abort_cap_valid", bus.resp_valid, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("abort");
    rst = 1'b1;
    sweep_check("resweep");

    // Memory was cleared again
    do_req(1'b0, 16'h0005, 16'h0000, 16'h0000, 1'b0, 3, 0);
    wait_idle();
    repeat (4) @(negedge clk);

    chk("strobe_overlap", overlap, 0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/data_mem_access_ctrl.md
Name: data_mem_access_ctrl

Overview:
- Initiator side of the data-memory port: accepts load/store requests from the CPU datapath over a valid/ready handshake.
- Sequences the memory strobes (wr_en, rd_en, mem_address, data_in) and captures data_out.
- Returns a response over a second valid/ready handshake.
- After reset, optionally sweeps the whole memory to zero before accepting requests.
- Sits between the execute stage and the data memory in the CPU top level.

Parameters:
DATA_W, 16, data word width (matches memory data_in/data_out)
ADDR_W, 6, memory word-address width driven on mem_address
DEPTH, 64, number of memory words; must equal 2**ADDR_W
INIT_CLEAR, 1, 1 = zero all DEPTH words after reset; 0 = go straight to IDLE

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request this cycle
req_we  in  1  1 = store, 0 = load
req_addr  in  16  word address from ALU
req_wdata  in  DATA_W  store data
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_rdata  out  DATA_W  load data (0 for stores and errors)
resp_err  out  1  address out of range, no access performed
init_done  out  1  clear sweep finished (or skipped)
mem_wr_en  out  1  to memory wr_en
mem_rd_en  out  1  to memory rd_en
mem_address  out  ADDR_W  to memory mem_address
mem_data_in  out  DATA_W  to memory data_in
mem_data_out  in  DATA_W  from memory data_out; valid the cycle after rd_en is sampled

Behaviour:
- Reset (rst=0 at a rising edge) takes effect regardless of state, including mid-transaction:
  - state goes to INIT (INIT_CLEAR=1) or IDLE (INIT_CLEAR=0).
  - All outputs are 0 (init_done=1 when INIT_CLEAR=0).
  - Any in-flight request or response is dropped.
- The memory's own reset is driven separately at top level; this block does not drive it.
- All outputs are registered; memory strobes are Moore outputs of state.
- mem_wr_en and mem_rd_en are never both 1.
- States:
  - INIT: mem_wr_en=1, mem_data_in=0, mem_address = init counter.
    - Counter runs 0..DEPTH-1, one word per cycle.
    - After the write of DEPTH-1: go to IDLE and set init_done=1.
    - Exactly DEPTH write cycles; req_ready=0 throughout.
  - IDLE: req_ready=1, strobes 0. On req_valid&&req_ready, latch req_we/req_addr/req_wdata.
    - req_addr[15:ADDR_W] != 0: go to RESP with resp_err=1 and resp_rdata=0; no strobe is issued.
    - Valid store: go to WR.
    - Valid load: go to RD.
  - WR: one cycle, mem_wr_en=1, mem_address = addr[ADDR_W-1:0], mem_data_in = wdata. Then go to RESP with resp_rdata=0.
  - RD: one cycle, mem_rd_en=1, mem_address latched. Then go to CAP.
  - CAP: strobes 0. At the end of the cycle, register mem_data_out into resp_rdata. Then go to RESP.
  - RESP: resp_valid=1; resp_rdata and resp_err held stable.
    - Wait for resp_ready, then go to IDLE with resp_valid=0.
    - resp_ready asserted in the first RESP cycle completes that same cycle.
- Latency from the request-accept edge to the first resp_valid cycle:
  - store: 2 cycles; load: 3 cycles; error: 1 cycle.
  - Best-case throughput: one store every 3 cycles, one load every 4.
- req_ready is 0 outside IDLE; there is no request buffering and no back-to-back acceptance.
- resp_ready while resp_valid=0 is ignored.
- resp_rdata and resp_err change only on entry to RESP and clear to 0 when leaving RESP.
- mem_address and mem_data_in hold their last value in non-strobe states; the memory ignores them there.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - state encoding (INIT, IDLE, WR, RD, CAP, RESP, 3-bit)
  - DATA_W/ADDR_W/DEPTH defaults
  - the RD-to-data latency constant MEM_RD_LAT=1
- No sub-module needed; the init counter is inline.

Test Plan:
- Reset then release, INIT_CLEAR=1 -> exactly 64 cycles of mem_wr_en=1 with mem_address 0..63 and data 0; init_done=1 on the next cycle; req_ready=1.
- Store addr 0x0005 data 0xBEEF, then load 0x0005 -> mem_wr_en for one cycle with address 5; load resp_rdata=0xBEEF and resp_err=0; latencies 2 and 3 cycles.
- Load addr 0x0040 -> resp_err=1, resp_rdata=0, no mem_rd_en/mem_wr_en pulse, resp_valid 1 cycle after accept.
- Load with resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready=0 throughout; completes on the resp_ready cycle.
- rst=0 asserted during the CAP state of a load -> next cycle all outputs 0, state INIT, no response is ever delivered for that load.
- Store to 63 and store to 0 back-to-back, then load both -> 63 and 0 each return their own value; strobes never overlap.
